bcd_scan_counter: RTL



---
 rtl/bcd_scan_pkg.sv | 31 +++
 rtl/bcd_decade.sv | 19 +
 rtl/bcd_scan_counter.sv | 87 ++++++++
 3 files changed

// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg: BCD digit / 7-segment types, segment patterns and the digit decoder.
package bcd_scan_pkg;
  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  function automatic seg_t seg7(input bcd_t d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/bcd_decade.sv
// bcd_decade: combinational next value and carry/borrow of one BCD decade.
module bcd_decade
  import bcd_scan_pkg::*;
(
  input  bcd_t digit_i,
  input  logic up_dn_i,
  input  logic cin_i,
  output bcd_t next_o,
  output logic cout_o
);
  logic edge_hit;
  always_comb begin
    edge_hit = up_dn_i ? (digit_i >= 4'd9) : (digit_i == 4'd0);
    cout_o = cin_i && edge_hit;
    next_o = !cin_i ? digit_i :
             up_dn_i ? (edge_hit ? 4'd0 : digit_i + 4'd1) :
             (edge_hit ? 4'd9 : digit_i - 4'd1);
  end
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: N-decade BCD up/down counter with load, prescaler and 7-segment scan.
// Define BCD_SCAN_COUNTER_LZB_EN to blank leading zeros on the display.
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 3,
  parameter int TICK_DIV    = 1000000,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] bcd_value,
  output logic                    wrap,
  output seg_t                    seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  bcd_t [NUM_DIGITS-1:0] cnt_q, cnt_d, inc, ld;
  logic [NUM_DIGITS:0] c;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  seg_t seg_q, seg_d;
  logic wrap_q, wrap_d, step, adv, blank;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    bcd_decade u_dec (
      .digit_i(cnt_q[i]),
      .up_dn_i(up_dn),
      .cin_i  (c[i]),
      .next_o (inc[i]),
      .cout_o (c[i+1])
    );
    assign ld[i] = load_val[4*i +: 4] > 4'd9 ? 4'd0 : load_val[4*i +: 4];
  end
`ifdef BCD_SCAN_COUNTER_LZB_EN
  logic [NUM_DIGITS:0] lz;
  always_comb begin
    lz[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) lz[k] = lz[k+1] && cnt_q[k] == 4'd0;
  end
  assign blank = idx_d != '0 && lz[idx_d];
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    step    = enable && presc_q == PW'(TICK_DIV - 1);
    presc_d = (load || step) ? '0 : enable ? presc_q + 1'b1 : presc_q;
    cnt_d   = load ? ld : step ? inc : cnt_q;
    wrap_d  = !load && step && c[NUM_DIGITS];
    adv     = ref_q == RW'(REFRESH_DIV - 1);
    ref_d   = adv ? '0 : ref_q + 1'b1;
    idx_d   = !adv ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
    sel_d   = adv ? NUM_DIGITS'(1) << idx_d : sel_q;
    seg_d   = !adv ? seg_q : blank ? '0 : seg7(cnt_q[idx_d]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      seg_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end
  assign bcd_value = cnt_q;
  assign wrap      = wrap_q;
  assign seg_out   = seg_q;
  assign digit_sel = sel_q;
endmodule
